// File: rtl/flow_tracker_p.sv
// flow_tracker_p: 3-cycle classify/update engine over a direct-mapped flow table.
// Define FT_DIR_STATS_EN to keep per-direction packet counters per entry.
module flow_tracker_p #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned HASH_W     = 32,
  parameter int unsigned SIZE_W     = 16,
  parameter int unsigned TIME_W     = 16,
  parameter int unsigned TUPLE_W    = 104,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned SIZE_SHIFT = 6
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [HASH_W-1:0]                 hash,
  input  logic [HASH_W-1:0]                 r_hash,
  input  logic                              hash_v,
  output logic                              in_ready,
  input  logic [SIZE_W-1:0]                 i_pkt_size,
  input  logic [TUPLE_W-1:0]                tuple,
  input  logic [TIME_W-1:0]                 pkt_arvt,
  input  logic [CNT_W-1:0]                  threshold,
  input  logic                              free_addr_v,
  input  logic [ADDR_W-1:0]                 free_addr,
  output logic                              o_v,
  output logic                              hit,
  output logic                              dir,
  output logic                              collision,
  output logic [ADDR_W-1:0]                 flow_addr,
  output logic [HASH_W-1:0]                 o_hash,
  output logic [HASH_W-1:0]                 o_r_hash,
  output logic [CNT_W-1:0]                  o_pkt_size,
  output logic [CNT_W-1:0]                  o_pkt_arit,
  output logic [CNT_W-1:0]                  o_n_pkt,
  output logic [CNT_W-1:0]                  o_flow_durt,
  output logic [CNT_W-1:0]                  o_flow_size,
  output logic                              reach_thrh,
  output logic [CNT_W-1:0]                  o_n_pkt_dir,
  output logic [SIZE_W+TUPLE_W+TIME_W-1:0]  meta_fea,
  output logic                              meta_fea_v
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned BYTE_W = SIZE_W + CNT_W;
  localparam int unsigned WIDE_W = BYTE_W + TIME_W;
  localparam int unsigned META_W = SIZE_W + TUPLE_W + TIME_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE} state_t;

  typedef struct packed {
    logic [HASH_W-1:0] tag;
    logic [TIME_W-1:0] first_arvt;
    logic [TIME_W-1:0] last_arvt;
    logic [CNT_W-1:0]  n_pkt;
    logic [BYTE_W-1:0] bytes;
`ifdef FT_DIR_STATS_EN
    logic [CNT_W-1:0]  n_dir0;
    logic [CNT_W-1:0]  n_dir1;
`endif
  } entry_t;

  typedef struct packed {
    logic              hit;
    logic              dir;
    logic              coll;
    logic [ADDR_W-1:0] addr;
    logic [HASH_W-1:0] hash;
    logic [HASH_W-1:0] r_hash;
    logic [CNT_W-1:0]  pkt_size;
    logic [CNT_W-1:0]  pkt_arit;
    logic [CNT_W-1:0]  n_pkt;
    logic [CNT_W-1:0]  flow_durt;
    logic [CNT_W-1:0]  flow_size;
    logic              reach;
    logic [CNT_W-1:0]  n_pkt_dir;
    logic [META_W-1:0] meta;
  } result_t;

  function automatic logic [CNT_W-1:0] sat(input logic [WIDE_W-1:0] x);
    return ((x >> CNT_W) != '0) ? '1 : x[CNT_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] x);
    return (x == '1) ? x : x + CNT_W'(1);
  endfunction

  state_t             state_q, state_d;
  logic [DEPTH-1:0]   valid_q;
  entry_t             table_mem [DEPTH];
  entry_t             rd_m_q, rd_r_q;
  logic [HASH_W-1:0]  hash_q, r_hash_q;
  logic [SIZE_W-1:0]  size_q;
  logic [TUPLE_W-1:0] tuple_q;
  logic [TIME_W-1:0]  arvt_q;
  logic [CNT_W-1:0]   thr_q;

  logic               hit_q, dir_q, coll_q, kill_q;
  logic [ADDR_W-1:0]  addr_q;
  entry_t             old_q;

  logic               lk_hit, lk_dir, lk_coll;
  logic [ADDR_W-1:0]  lk_addr, m_addr, r_addr;
  entry_t             lk_old;

  entry_t             wr_entry;
  logic               wr_en;
  logic [CNT_W-1:0]   n_upd, ndir_upd;
  logic [BYTE_W:0]    bsum;
  logic [BYTE_W-1:0]  bytes_upd;
  logic [TIME_W-1:0]  arit_raw, durt_raw;
  logic               accept;
  logic               o_v_q;
  result_t            res_q, res_d;

  assign in_ready = (state_q == IDLE) && !rst;
  assign accept   = hash_v && in_ready;
  assign m_addr   = hash_q[ADDR_W-1:0];
  assign r_addr   = r_hash_q[ADDR_W-1:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = LOOKUP;
      LOOKUP:  state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Valid bits are read live in LOOKUP so a free issued in the accept cycle is honoured.
  always_comb begin
    lk_hit  = 1'b0;
    lk_dir  = 1'b0;
    lk_coll = 1'b0;
    lk_addr = m_addr;
    lk_old  = rd_m_q;
    if (valid_q[m_addr] && rd_m_q.tag == hash_q) begin
      lk_hit = 1'b1;
    end else if (valid_q[r_addr] && rd_r_q.tag == r_hash_q) begin
      lk_hit  = 1'b1;
      lk_dir  = 1'b1;
      lk_addr = r_addr;
      lk_old  = rd_r_q;
    end else if (valid_q[m_addr]) begin
      lk_coll = 1'b1;
    end
  end

  always_comb begin
    n_upd     = CNT_W'(1);
    bsum      = '0;
    bytes_upd = BYTE_W'(size_q);
    arit_raw  = '0;
    durt_raw  = '0;
    wr_entry  = '0;
    ndir_upd  = '0;
    if (hit_q) begin
      n_upd     = inc_sat(old_q.n_pkt);
      bsum      = {1'b0, old_q.bytes} + {{(CNT_W + 1){1'b0}}, size_q};
      bytes_upd = bsum[BYTE_W] ? '1 : bsum[BYTE_W-1:0];
      arit_raw  = arvt_q - old_q.last_arvt;
      durt_raw  = arvt_q - old_q.first_arvt;
    end
    wr_entry.tag        = hit_q ? old_q.tag : hash_q;
    wr_entry.first_arvt = hit_q ? old_q.first_arvt : arvt_q;
    wr_entry.last_arvt  = arvt_q;
    wr_entry.n_pkt      = n_upd;
    wr_entry.bytes      = bytes_upd;
`ifdef FT_DIR_STATS_EN
    wr_entry.n_dir0 = CNT_W'(1);
    wr_entry.n_dir1 = '0;
    if (hit_q) begin
      wr_entry.n_dir0 = dir_q ? old_q.n_dir0 : inc_sat(old_q.n_dir0);
      wr_entry.n_dir1 = dir_q ? inc_sat(old_q.n_dir1) : old_q.n_dir1;
    end
    ndir_upd = dir_q ? wr_entry.n_dir1 : wr_entry.n_dir0;
`endif
  end

  assign wr_en = (state_q == UPDATE) && !rst && !coll_q && !kill_q &&
                 !(free_addr_v && free_addr == addr_q);

  always_comb begin
    res_d = res_q;
    if (state_q == UPDATE) begin
      res_d.hit       = hit_q;
      res_d.dir       = dir_q;
      res_d.coll      = coll_q;
      res_d.addr      = addr_q;
      res_d.hash      = hash_q;
      res_d.r_hash    = r_hash_q;
      res_d.pkt_size  = sat(WIDE_W'(size_q >> SIZE_SHIFT));
      res_d.pkt_arit  = sat(WIDE_W'(arit_raw));
      res_d.n_pkt     = n_upd;
      res_d.flow_durt = sat(WIDE_W'(durt_raw));
      res_d.flow_size = sat(WIDE_W'(bytes_upd >> SIZE_SHIFT));
      // A saturated count that stays at threshold must not re-fire.
      res_d.reach     = (n_upd == thr_q) && (thr_q != '0) &&
                        !(hit_q && old_q.n_pkt == n_upd);
      res_d.n_pkt_dir = ndir_upd;
      res_d.meta      = {size_q, tuple_q, arvt_q};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      o_v_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      o_v_q   <= (state_q == UPDATE);
      res_q   <= res_d;
      if (wr_en) valid_q[addr_q] <= 1'b1;
      if (free_addr_v) valid_q[free_addr] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      rd_m_q   <= table_mem[hash[ADDR_W-1:0]];
      rd_r_q   <= table_mem[r_hash[ADDR_W-1:0]];
      hash_q   <= hash;
      r_hash_q <= r_hash;
      size_q   <= i_pkt_size;
      tuple_q  <= tuple;
      arvt_q   <= pkt_arvt;
      thr_q    <= threshold;
    end
    if (state_q == LOOKUP) begin
      hit_q  <= lk_hit;
      dir_q  <= lk_dir;
      coll_q <= lk_coll;
      addr_q <= lk_addr;
      old_q  <= lk_old;
      kill_q <= free_addr_v && (free_addr == lk_addr);
    end
    if (wr_en) table_mem[addr_q] <= wr_entry;
  end

  assign o_v         = o_v_q;
  assign meta_fea_v  = o_v_q;
  assign hit         = res_q.hit;
  assign dir         = res_q.dir;
  assign collision   = res_q.coll;
  assign flow_addr   = res_q.addr;
  assign o_hash      = res_q.hash;
  assign o_r_hash    = res_q.r_hash;
  assign o_pkt_size  = res_q.pkt_size;
  assign o_pkt_arit  = res_q.pkt_arit;
  assign o_n_pkt     = res_q.n_pkt;
  assign o_flow_durt = res_q.flow_durt;
  assign o_flow_size = res_q.flow_size;
  assign reach_thrh  = res_q.reach;
  assign o_n_pkt_dir = res_q.n_pkt_dir;
  assign meta_fea    = res_q.meta;

endmodule

// File: tb/tb_flow_tracker_p.sv
// Directed self-checking bench for flow_tracker_p (default parameters).
module tb_flow_tracker_p;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  hash, r_hash;
  logic         hash_v;
  logic         in_ready;
  logic [15:0]  i_pkt_size;
  logic [103:0] tuple;
  logic [15:0]  pkt_arvt;
  logic [7:0]   threshold;
  logic         free_addr_v;
  logic [11:0]  free_addr;
  logic         o_v, hit, dir, collision, reach_thrh, meta_fea_v;
  logic [11:0]  flow_addr;
  logic [31:0]  o_hash, o_r_hash;
  logic [7:0]   o_pkt_size, o_pkt_arit, o_n_pkt, o_flow_durt, o_flow_size, o_n_pkt_dir;
  logic [135:0] meta_fea;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  flow_tracker_p #(
    .ADDR_W(12), .HASH_W(32), .SIZE_W(16), .TIME_W(16),
    .TUPLE_W(104), .CNT_W(8), .SIZE_SHIFT(6)
  ) dut (
    .clk(clk), .rst(rst), .hash(hash), .r_hash(r_hash), .hash_v(hash_v),
    .in_ready(in_ready), .i_pkt_size(i_pkt_size), .tuple(tuple),
    .pkt_arvt(pkt_arvt), .threshold(threshold), .free_addr_v(free_addr_v),
    .free_addr(free_addr), .o_v(o_v), .hit(hit), .dir(dir),
    .collision(collision), .flow_addr(flow_addr), .o_hash(o_hash),
    .o_r_hash(o_r_hash), .o_pkt_size(o_pkt_size), .o_pkt_arit(o_pkt_arit),
    .o_n_pkt(o_n_pkt), .o_flow_durt(o_flow_durt), .o_flow_size(o_flow_size),
    .reach_thrh(reach_thrh), .o_n_pkt_dir(o_n_pkt_dir), .meta_fea(meta_fea),
    .meta_fea_v(meta_fea_v)
  );

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one packet, optionally pulse a free of free_addr on the given
  // cycle after accept, and wait (bounded) for the result pulse.
  task automatic send(input logic [31:0] h, input logic [31:0] rh,
                      input logic [15:0] sz, input logic [15:0] at,
                      input int unsigned free_cyc, input logic [11:0] fa);
    int unsigned lat;
    @(negedge clk);
    for (int unsigned w = 0; w < 10 && !in_ready; w++) @(negedge clk);
    chk("rdy_wait", in_ready, 1'b1);
    hash       = h;
    r_hash     = rh;
    i_pkt_size = sz;
    pkt_arvt   = at;
    tuple      = {h, rh, 40'hC0FFEE0042};
    hash_v     = 1'b1;
    @(posedge clk);
    #1 hash_v = 1'b0;
    lat = 99;
    for (int unsigned i = 1; i <= 6; i++) begin
      @(negedge clk);
      free_addr_v = (i == free_cyc);
      free_addr   = fa;
      if (o_v) begin
        lat = i;
        break;
      end
    end
    chk("latency", lat, 3);
  endtask

  task automatic expect_pkt(input string t, input logic h, input logic d, input logic c,
                            input logic [11:0] a, input logic [7:0] n, input logic [7:0] ps,
                            input logic [7:0] ar, input logic [7:0] du, input logic [7:0] fs,
                            input logic rt, input logic [7:0] nd);
    chk({t, ".hit"},  hit, h);
    chk({t, ".dir"},  dir, d);
    chk({t, ".coll"}, collision, c);
    chk({t, ".addr"}, flow_addr, a);
    chk({t, ".npkt"}, o_n_pkt, n);
    chk({t, ".psz"},  o_pkt_size, ps);
    chk({t, ".arit"}, o_pkt_arit, ar);
    chk({t, ".durt"}, o_flow_durt, du);
    chk({t, ".fsz"},  o_flow_size, fs);
    chk({t, ".reach"}, reach_thrh, rt);
    chk({t, ".metav"}, meta_fea_v, 1'b1);
`ifdef FT_DIR_STATS_EN
    chk({t, ".ndir"}, o_n_pkt_dir, nd);
`else
    chk({t, ".ndir"}, o_n_pkt_dir, 8'd0);
    if (nd == 8'hFF) n_chk += 0;
`endif
  endtask

  initial begin
    int unsigned reach_cnt;
    int unsigned ov_cnt;
    logic [135:0] exp_meta;
    rst = 1'b1; hash = '0; r_hash = '0; hash_v = 1'b0; i_pkt_size = '0;
    tuple = '0; pkt_arvt = '0; threshold = '0; free_addr_v = 1'b0; free_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.ready", in_ready, 1'b0);
    chk("rst.ov", o_v, 1'b0);
    chk("rst.npkt", o_n_pkt, 8'd0);
    chk("rst.meta", meta_fea, 136'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.ready_after", in_ready, 1'b1);

    // new flow, reverse hit, threshold, collision
    send(32'h00000A05, 32'h00000B07, 16'd640, 16'd100, 0, 12'd0);
    expect_pkt("p1", 0, 0, 0, 12'hA05, 1, 10, 0, 0, 10, 0, 1);
    exp_meta = {16'd640, 32'h00000A05, 32'h00000B07, 40'hC0FFEE0042, 16'd100};
    chk("p1.meta", meta_fea, exp_meta);
    chk("p1.ohash", o_hash, 32'h00000A05);
    chk("p1.orhash", o_r_hash, 32'h00000B07);
    send(32'h00000B07, 32'h00000A05, 16'd64, 16'd130, 0, 12'd0);
    expect_pkt("p2", 1, 1, 0, 12'hA05, 2, 1, 30, 30, 11, 0, 1);
    threshold = 8'd3;
    send(32'h00000A05, 32'h00000B07, 16'd128, 16'd150, 0, 12'd0);
    expect_pkt("p3", 1, 0, 0, 12'hA05, 3, 2, 20, 50, 13, 1, 2);
    send(32'h00000A05, 32'h00000B07, 16'd64, 16'd160, 0, 12'd0);
    expect_pkt("p4", 1, 0, 0, 12'hA05, 4, 1, 10, 60, 14, 0, 3);
    send(32'h12340A05, 32'h00000C01, 16'd64, 16'd170, 0, 12'd0);
    expect_pkt("p5coll", 0, 0, 1, 12'hA05, 1, 1, 0, 0, 1, 0, 1);
    send(32'h00000A05, 32'h00000B07, 16'd64, 16'd180, 0, 12'd0);
    expect_pkt("p6", 1, 0, 0, 12'hA05, 5, 1, 20, 80, 15, 0, 4);

    // saturation: packets 7..300, threshold 255 must fire exactly once
    threshold = 8'd255;
    reach_cnt = 0;
    for (int k = 7; k <= 300; k++) begin
      send(32'h00000A05, 32'h00000B07, 16'd640, 16'(180 + (k - 6) * 2), 0, 12'd0);
      if (reach_thrh) reach_cnt++;
    end
    chk("sat.npkt", o_n_pkt, 8'd255);
    chk("sat.fsz", o_flow_size, 8'd255);
    chk("sat.arit", o_pkt_arit, 8'd2);
    chk("sat.durt", o_flow_durt, 8'd255);
    chk("sat.reach_once", reach_cnt, 1);

    // free during UPDATE: outputs still produced, entry gone afterwards
    threshold = 8'd0;
    send(32'h00000A05, 32'h00000B07, 16'd64, 16'd800, 2, 12'hA05);
    expect_pkt("free", 1, 0, 0, 12'hA05, 255, 1, 32, 255, 255, 0, 255);
    send(32'h00000A05, 32'h00000B07, 16'd64, 16'd65530, 0, 12'd0);
    expect_pkt("relearn", 0, 0, 0, 12'hA05, 1, 1, 0, 0, 1, 0, 1);
    send(32'h00000A05, 32'h00000B07, 16'd64, 16'd4, 0, 12'd0);
    expect_pkt("wrap", 1, 0, 0, 12'hA05, 2, 1, 10, 10, 2, 0, 2);

    // back-to-back: hash_v held high
    @(negedge clk);
    hash = 32'h00000333; r_hash = 32'h00000444; i_pkt_size = 16'd64;
    pkt_arvt = 16'd500; tuple = '1; hash_v = 1'b1;
    ov_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("bb.ready%0d", i), in_ready, (i % 3) == 0);
      if (o_v) ov_cnt++;
      @(negedge clk);
    end
    hash_v = 1'b0;
    chk("bb.ov_cnt", ov_cnt, 3);
    chk("bb.last_ov", o_v, 1'b1);
    chk("bb.npkt", o_n_pkt, 8'd4);

    // reset while a packet is in LOOKUP
    @(negedge clk);
    hash = 32'h00000777; r_hash = 32'h00000888; hash_v = 1'b1;
    @(posedge clk);
    #1 hash_v = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rstl.ready", in_ready, 1'b0);
    chk("rstl.npkt", o_n_pkt, 8'd0);
    rst = 1'b0;
    ov_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (o_v) ov_cnt++;
      @(negedge clk);
    end
    chk("rstl.no_ov", ov_cnt, 0);
    send(32'h00000A05, 32'h00000B07, 16'd64, 16'd20, 0, 12'd0);
    expect_pkt("rstl.a05", 0, 0, 0, 12'hA05, 1, 1, 0, 0, 1, 0, 1);
    send(32'h00000333, 32'h00000444, 16'd64, 16'd30, 0, 12'd0);
    expect_pkt("rstl.333", 0, 0, 0, 12'h333, 1, 1, 0, 0, 1, 0, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
